// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter: request record, FSM state and channel ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_bus_pkg;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  // One request as presented by either core port and as driven downstream.
  typedef struct packed {
    logic        mode;   // BUS_READ / BUS_WRITE
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_e;

  typedef enum logic {
    CH_FETCH,
    CH_MEM
  } ch_id_e;

  // The channel that is not 'c'; used for round-robin tie-break.
  function automatic ch_id_e other_ch(input ch_id_e c);
    return (c == CH_FETCH) ? CH_MEM : CH_FETCH;
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundle of the two core-side pulse ports plus the merged downstream pulse port.
// Latency: n/a (wiring only).
// Backpressure: none; every port is a one-cycle enable pulse without a ready.
// Modports:
//   slave  - arbiter view: takes core requests and downstream responses, drives the rest.
//   master - environment view (core + memory model), the mirror image.
interface core_bus_arbiter_if;

  // fetch port
  logic        fetch_request_enable;
  logic        freq_mode;
  logic [31:0] freq_addr;
  logic [31:0] freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;

  // data port
  logic        mem_request_enable;
  logic        mreq_mode;
  logic [31:0] mreq_addr;
  logic [31:0] mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;

  // downstream memory port
  logic        bus_req_enable;
  logic        bus_req_mode;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_enable;
  logic [31:0] bus_resp_data;

  logic        protocol_error;

  modport slave (
    input  fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
    output fetch_response_enable, fresp_data,
    input  mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
    output mem_response_enable, mresp_data,
    output bus_req_enable, bus_req_mode, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_resp_enable, bus_resp_data,
    output protocol_error
  );

  modport master (
    output fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
    input  fetch_response_enable, fresp_data,
    output mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
    input  mem_response_enable, mresp_data,
    input  bus_req_enable, bus_req_mode, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_resp_enable, bus_resp_data,
    input  protocol_error
  );

endinterface

// File: rtl/core_bus_arbiter_req_slot.sv
// One-entry request buffer for a single arbiter channel.
// Latency: load visible on pending_o/req_o the cycle after the load pulse.
// Backpressure: none; a load while full or while the channel is busy is dropped and flagged on ovf_o.
// Ports:
//   clk, rst          clock, async active-high reset
//   load_i, req_i     capture request pulse and its fields
//   clear_i           entry consumed by the arbiter this cycle
//   busy_i            channel has a transaction in flight that is not completing this cycle
//   pending_o, req_o  stored entry
//   ovf_o             combinational: load_i arrived while it could not be accepted
module req_slot
  import core_bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic     clear_i,
  input  logic     busy_i,
  input  bus_req_t req_i,
  output logic     pending_o,
  output bus_req_t req_o,
  output logic     ovf_o
);

  logic     pending_q, pending_d;
  bus_req_t data_q, data_d;
  logic     accept;

  // Existing entry always wins; an offending pulse is simply discarded.
  assign accept = load_i & ~pending_q & ~busy_i;
  assign ovf_o  = load_i & (pending_q | busy_i);

  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d = 1'b1;
      data_d    = req_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign pending_o = pending_q;
  assign req_o     = data_q;

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges the core fetch and data pulse ports onto one downstream port, one transaction outstanding.
// Latency: request pulse in T (arbiter idle) -> bus_req_enable in T+1; bus response in R -> channel response in R+1.
// Backpressure: none; one buffered request per channel, extra pulses are dropped and set protocol_error.
// Ports:
//   clk, rst  clock, async active-high reset
//   bus       core_bus_arbiter_if.slave: fetch port, data port, downstream port, protocol_error
// Parameter MEM_FIRST: 1 = data channel wins the first simultaneous request after reset.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  core_bus_arbiter_if.slave   bus
);

  arb_state_e  state_q, state_d;
  ch_id_e      owner_q, owner_d;
  ch_id_e      last_q, last_d;
  bus_req_t    breq_q, breq_d;
  logic        breq_en_q, breq_en_d;
  logic        fresp_en_q, fresp_en_d;
  logic        mresp_en_q, mresp_en_d;
  logic [31:0] fresp_data_q, fresp_data_d;
  logic [31:0] mresp_data_q, mresp_data_d;
  logic        err_q, err_d;

  bus_req_t    freq_in, mreq_in;
  bus_req_t    f_buf, m_buf;
  logic        f_pend, m_pend;
  logic        f_ovf, m_ovf;
  logic        f_busy, m_busy;
  logic        f_load, m_load;
  logic        f_clear, m_clear;
  logic        f_bypass, m_bypass;
  logic        cand_f, cand_m;
  ch_id_e      gnt_ch;
  logic        stray;

  assign freq_in = {bus.freq_mode, bus.freq_addr, bus.freq_wdata, bus.freq_wstrb};
  assign mreq_in = {bus.mreq_mode, bus.mreq_addr, bus.mreq_wdata, bus.mreq_wstrb};

  // In-flight clears on the response edge, so the owner may issue a new pulse in the response cycle.
  assign f_busy = (state_q == WAIT) && (owner_q == CH_FETCH) && !bus.bus_resp_enable;
  assign m_busy = (state_q == WAIT) && (owner_q == CH_MEM)   && !bus.bus_resp_enable;

  // A pulse granted straight through in IDLE never enters its buffer.
  assign f_load = bus.fetch_request_enable & ~f_bypass;
  assign m_load = bus.mem_request_enable   & ~m_bypass;

  req_slot u_fetch_slot (
    .clk       (clk),
    .rst       (rst),
    .load_i    (f_load),
    .clear_i   (f_clear),
    .busy_i    (f_busy),
    .req_i     (freq_in),
    .pending_o (f_pend),
    .req_o     (f_buf),
    .ovf_o     (f_ovf)
  );

  req_slot u_mem_slot (
    .clk       (clk),
    .rst       (rst),
    .load_i    (m_load),
    .clear_i   (m_clear),
    .busy_i    (m_busy),
    .req_i     (mreq_in),
    .pending_o (m_pend),
    .req_o     (m_buf),
    .ovf_o     (m_ovf)
  );

  // A buffered entry takes precedence over a same-cycle pulse (which then overflows).
  assign cand_f = f_pend | bus.fetch_request_enable;
  assign cand_m = m_pend | bus.mem_request_enable;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    breq_d       = breq_q;
    breq_en_d    = 1'b0;
    fresp_en_d   = 1'b0;
    mresp_en_d   = 1'b0;
    fresp_data_d = fresp_data_q;
    mresp_data_d = mresp_data_q;
    f_clear      = 1'b0;
    m_clear      = 1'b0;
    f_bypass     = 1'b0;
    m_bypass     = 1'b0;
    stray        = 1'b0;
    gnt_ch       = CH_FETCH;

    case (state_q)
      IDLE: begin
        if (cand_f && cand_m) begin
          gnt_ch = other_ch(last_q);
        end else if (cand_m) begin
          gnt_ch = CH_MEM;
        end else begin
          gnt_ch = CH_FETCH;
        end

        if (cand_f || cand_m) begin
          breq_en_d = 1'b1;
          owner_d   = gnt_ch;
          last_d    = gnt_ch;
          state_d   = WAIT;
          if (gnt_ch == CH_FETCH) begin
            if (f_pend) begin
              breq_d  = f_buf;
              f_clear = 1'b1;
            end else begin
              breq_d   = freq_in;
              f_bypass = 1'b1;
            end
          end else begin
            if (m_pend) begin
              breq_d  = m_buf;
              m_clear = 1'b1;
            end else begin
              breq_d   = mreq_in;
              m_bypass = 1'b1;
            end
          end
        end

        // Nothing is outstanding, so any response here is unsolicited.
        stray = bus.bus_resp_enable;
      end

      WAIT: begin
        if (bus.bus_resp_enable) begin
          if (owner_q == CH_FETCH) begin
            fresp_en_d   = 1'b1;
            fresp_data_d = bus.bus_resp_data;
          end else begin
            mresp_en_d   = 1'b1;
            mresp_data_d = bus.bus_resp_data;
          end
          state_d = IDLE;
        end
      end
    endcase
  end

  assign err_d = err_q | f_ovf | m_ovf | stray;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= CH_FETCH;
      last_q       <= MEM_FIRST ? CH_FETCH : CH_MEM;
      breq_q       <= '0;
      breq_en_q    <= 1'b0;
      fresp_en_q   <= 1'b0;
      mresp_en_q   <= 1'b0;
      fresp_data_q <= '0;
      mresp_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      breq_q       <= breq_d;
      breq_en_q    <= breq_en_d;
      fresp_en_q   <= fresp_en_d;
      mresp_en_q   <= mresp_en_d;
      fresp_data_q <= fresp_data_d;
      mresp_data_q <= mresp_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.bus_req_enable        = breq_en_q;
  assign bus.bus_req_mode          = breq_q.mode;
  assign bus.bus_req_addr          = breq_q.addr;
  assign bus.bus_req_wdata         = breq_q.wdata;
  assign bus.bus_req_wstrb         = breq_q.wstrb;
  assign bus.fetch_response_enable = fresp_en_q;
  assign bus.fresp_data            = fresp_data_q;
  assign bus.mem_response_enable   = mresp_en_q;
  assign bus.mresp_data            = mresp_data_q;
  assign bus.protocol_error        = err_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter (MEM_FIRST=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_core_bus_arbiter;
  import core_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  core_bus_arbiter_if bus_if ();

  core_bus_arbiter #(.MEM_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.fetch_request_enable = 1'b0;
    bus_if.freq_mode            = 1'b0;
    bus_if.freq_addr            = '0;
    bus_if.freq_wdata           = '0;
    bus_if.freq_wstrb           = '0;
    bus_if.mem_request_enable   = 1'b0;
    bus_if.mreq_mode            = 1'b0;
    bus_if.mreq_addr            = '0;
    bus_if.mreq_wdata           = '0;
    bus_if.mreq_wstrb           = '0;
    bus_if.bus_resp_enable      = 1'b0;
    bus_if.bus_resp_data        = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fetch_req(input logic m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_if.fetch_request_enable = 1'b1;
    bus_if.freq_mode  = m;
    bus_if.freq_addr  = a;
    bus_if.freq_wdata = d;
    bus_if.freq_wstrb = s;
  endtask

  task automatic mem_req(input logic m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_if.mem_request_enable = 1'b1;
    bus_if.mreq_mode  = m;
    bus_if.mreq_addr  = a;
    bus_if.mreq_wdata = d;
    bus_if.mreq_wstrb = s;
  endtask

  task automatic resp(input logic [31:0] d);
    bus_if.bus_resp_enable = 1'b1;
    bus_if.bus_resp_data   = d;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk("rst_bus_req_en", bus_if.bus_req_enable, 0);
    chk("rst_bus_req_addr", bus_if.bus_req_addr, 0);
    chk("rst_fresp_en", bus_if.fetch_response_enable, 0);
    chk("rst_mresp_en", bus_if.mem_response_enable, 0);
    chk("rst_err", bus_if.protocol_error, 0);
    rst = 1'b0;
    tick();

    // ---------------- single fetch read ----------------
    fetch_req(BUS_READ, 32'h0000_1000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    chk("t1_req_en", bus_if.bus_req_enable, 1);
    chk("t1_req_addr", bus_if.bus_req_addr, 32'h0000_1000);
    chk("t1_req_mode", bus_if.bus_req_mode, 0);
    tick();
    chk("t1_req_en_drop", bus_if.bus_req_enable, 0);
    chk("t1_req_addr_hold", bus_if.bus_req_addr, 32'h0000_1000);
    resp(32'hDEAD_BEEF);
    tick();
    clear_inputs();
    chk("t1_fresp_en", bus_if.fetch_response_enable, 1);
    chk("t1_fresp_data", bus_if.fresp_data, 32'hDEAD_BEEF);
    chk("t1_mresp_en", bus_if.mem_response_enable, 0);
    tick();
    chk("t1_fresp_en_pulse", bus_if.fetch_response_enable, 0);
    chk("t1_fresp_data_hold", bus_if.fresp_data, 32'hDEAD_BEEF);
    chk("t1_err", bus_if.protocol_error, 0);

    // ---------------- data write ----------------
    mem_req(BUS_WRITE, 32'h8000_0004, 32'h1234_5678, 4'hC);
    tick();
    clear_inputs();
    chk("t2_req_en", bus_if.bus_req_enable, 1);
    chk("t2_req_mode", bus_if.bus_req_mode, 1);
    chk("t2_req_addr", bus_if.bus_req_addr, 32'h8000_0004);
    chk("t2_req_wdata", bus_if.bus_req_wdata, 32'h1234_5678);
    chk("t2_req_wstrb", bus_if.bus_req_wstrb, 4'hC);
    tick();
    resp(32'h5555_0000);
    tick();
    clear_inputs();
    chk("t2_mresp_en", bus_if.mem_response_enable, 1);
    chk("t2_fresp_en", bus_if.fetch_response_enable, 0);
    chk("t2_mresp_data", bus_if.mresp_data, 32'h5555_0000);
    chk("t2_fresp_data_hold", bus_if.fresp_data, 32'hDEAD_BEEF);
    tick();

    // ---------------- simultaneous pulses after reset: data wins ----------------
    do_reset();
    fetch_req(BUS_READ, 32'h0000_2000, 32'h0, 4'h0);
    mem_req(BUS_READ, 32'h0000_3000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    chk("t3_first_en", bus_if.bus_req_enable, 1);
    chk("t3_first_addr", bus_if.bus_req_addr, 32'h0000_3000);
    tick();
    resp(32'hAAAA_0001);
    tick();                                   // R+1
    clear_inputs();
    chk("t3_mresp_en", bus_if.mem_response_enable, 1);
    chk("t3_mresp_data", bus_if.mresp_data, 32'hAAAA_0001);
    chk("t3_fresp_en0", bus_if.fetch_response_enable, 0);
    chk("t3_no_req_r1", bus_if.bus_req_enable, 0);
    tick();                                   // R+2: buffered fetch issues
    chk("t3_second_en", bus_if.bus_req_enable, 1);
    chk("t3_second_addr", bus_if.bus_req_addr, 32'h0000_2000);
    tick();
    resp(32'hBBBB_0002);
    tick();
    clear_inputs();
    chk("t3_fresp_en", bus_if.fetch_response_enable, 1);
    chk("t3_fresp_data", bus_if.fresp_data, 32'hBBBB_0002);
    chk("t3_mresp_en0", bus_if.mem_response_enable, 0);
    tick();

    // A lone data transaction leaves last_grant = data, so the next tie goes to fetch.
    mem_req(BUS_READ, 32'h0000_4000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    tick();
    resp(32'h0);
    tick();
    clear_inputs();
    tick();
    fetch_req(BUS_READ, 32'h0000_5000, 32'h0, 4'h0);
    mem_req(BUS_READ, 32'h0000_6000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    chk("t3b_first_addr", bus_if.bus_req_addr, 32'h0000_5000);
    tick();
    resp(32'hCCCC_0003);
    tick();
    clear_inputs();
    chk("t3b_fresp_en", bus_if.fetch_response_enable, 1);
    chk("t3b_fresp_data", bus_if.fresp_data, 32'hCCCC_0003);
    tick();
    chk("t3b_second_en", bus_if.bus_req_enable, 1);
    chk("t3b_second_addr", bus_if.bus_req_addr, 32'h0000_6000);
    tick();
    resp(32'hCCCC_0004);
    tick();
    clear_inputs();
    chk("t3b_mresp_en", bus_if.mem_response_enable, 1);
    chk("t3b_mresp_data", bus_if.mresp_data, 32'hCCCC_0004);
    chk("t3b_err", bus_if.protocol_error, 0);
    tick();

    // ---------------- overflow while in flight ----------------
    fetch_req(BUS_READ, 32'h0000_7000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    fetch_req(BUS_READ, 32'h0000_7777, 32'h0, 4'h0);
    tick();
    clear_inputs();
    chk("t4_err", bus_if.protocol_error, 1);
    chk("t4_addr_kept", bus_if.bus_req_addr, 32'h0000_7000);
    resp(32'h7070_7070);
    tick();
    clear_inputs();
    chk("t4_fresp_en", bus_if.fetch_response_enable, 1);
    chk("t4_fresp_data", bus_if.fresp_data, 32'h7070_7070);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_extra_req", bus_if.bus_req_enable, 0);
    end
    chk("t4_err_sticky", bus_if.protocol_error, 1);

    // ---------------- reset mid-WAIT, then a late response ----------------
    do_reset();
    fetch_req(BUS_READ, 32'h0000_8000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp(32'hFFFF_FFFF);
    tick();
    clear_inputs();
    chk("t5_fresp_en", bus_if.fetch_response_enable, 0);
    chk("t5_mresp_en", bus_if.mem_response_enable, 0);
    chk("t5_err", bus_if.protocol_error, 1);
    chk("t5_req_en", bus_if.bus_req_enable, 0);
    chk("t5_req_addr", bus_if.bus_req_addr, 0);
    chk("t5_fresp_data", bus_if.fresp_data, 0);

    // ---------------- data pulse in the fetch response cycle ----------------
    do_reset();
    fetch_req(BUS_READ, 32'h0000_9000, 32'h0, 4'h0);
    tick();
    clear_inputs();
    tick();
    resp(32'h9999_0000);
    mem_req(BUS_WRITE, 32'h0000_A000, 32'hA5A5_A5A5, 4'hF);
    tick();                                   // R+1
    clear_inputs();
    chk("t6_fresp_en", bus_if.fetch_response_enable, 1);
    chk("t6_no_req_r1", bus_if.bus_req_enable, 0);
    chk("t6_err_r1", bus_if.protocol_error, 0);
    tick();                                   // R+2
    chk("t6_req_en", bus_if.bus_req_enable, 1);
    chk("t6_req_addr", bus_if.bus_req_addr, 32'h0000_A000);
    chk("t6_req_wdata", bus_if.bus_req_wdata, 32'hA5A5_A5A5);
    chk("t6_err_r2", bus_if.protocol_error, 0);
    tick();
    resp(32'h0);
    tick();
    clear_inputs();
    chk("t6_mresp_en", bus_if.mem_response_enable, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
